// File: rtl/cfi_pkg.sv
// Shared definitions for the landing-pad checker: FSM states, exception causes,
// instruction opcodes and the link-register numbers used by the JALR filter.
package cfi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LP_EXPECTED = 2'd1,
        ST_FAULT       = 2'd2
    } cfi_state_e;

    localparam logic [1:0] CAUSE_NONE           = 2'b00;
    localparam logic [1:0] CAUSE_MISSING_LPAD   = 2'b01;
    localparam logic [1:0] CAUSE_LABEL_MISMATCH = 2'b10;

    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;
    localparam logic [4:0] REG_T2 = 5'd7;

    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

endpackage

// File: rtl/cfi_lp_decode.sv
// Combinational decode of a committing instruction: arming JALR, lpad, and the
// lpad label field (instr[31:32-LABEL_W]).
module cfi_lp_decode
    import cfi_pkg::*;
#(
    parameter int unsigned LABEL_W    = 20,
    parameter int unsigned CALLS_ONLY = 0
) (
    input  logic [31:0]        instr_i,
    output logic               arm_o,
    output logic               lpad_o,
    output logic [LABEL_W-1:0] label_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       filter_ok;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];

    // Calls-only mode arms on link writes; otherwise returns (rs1 = ra/t0) and
    // t2-based software-guarded jumps are exempt.
    assign filter_ok = (CALLS_ONLY != 0) ? is_link_reg(rd)
                                         : !(is_link_reg(rs1) || (rs1 == REG_T2));

    assign arm_o   = (opcode == OPC_JALR) && (funct3 == 3'b000) && filter_ok;
    assign lpad_o  = (opcode == OPC_AUIPC) && (rd == REG_X0);
    assign label_o = instr_i[31 -: LABEL_W];

endmodule

// File: rtl/cfi_lp_checker.sv
// Landing-pad (ELP) checker FSM. Optional violation counter enabled by defining
// macro CFI_LP_FAULT_CNT_EN; otherwise fault_cnt_o is tied to zero.
//
// state          | meaning
// ---------------+--------------------------------------------------------
// ST_IDLE        | no landing pad expected
// ST_LP_EXPECTED | indirect jump committed; next instruction must be lpad
// ST_FAULT       | violation raised, waiting for trap_ack_i
module cfi_lp_checker
    import cfi_pkg::*;
#(
    parameter int unsigned LABEL_W    = 20,
    parameter int unsigned CALLS_ONLY = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               instr_valid_i,
    input  logic [31:0]        instr_i,
    input  logic [LABEL_W-1:0] label_i,
    input  logic               elp_load_i,
    input  logic               elp_val_i,
    input  logic               trap_ack_i,
    output logic               elp_o,
    output logic               ex_o,
    output logic [1:0]         ex_cause_o,
    output logic [15:0]        fault_cnt_o
);

    cfi_state_e         state_q, state_d;
    logic [LABEL_W-1:0] label_q, label_d;
    logic [1:0]         cause_q, cause_d;

    logic               dec_arm;
    logic               dec_lpad;
    logic [LABEL_W-1:0] dec_label;
    logic               label_ok;

    cfi_lp_decode #(
        .LABEL_W    (LABEL_W),
        .CALLS_ONLY (CALLS_ONLY)
    ) u_decode (
        .instr_i (instr_i),
        .arm_o   (dec_arm),
        .lpad_o  (dec_lpad),
        .label_o (dec_label)
    );

    // A zero label on either side is a wildcard.
    assign label_ok = (dec_label == '0) || (label_q == '0) || (dec_label == label_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            label_q <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            label_q <= label_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        label_d = label_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (elp_load_i) begin
                    if (elp_val_i) begin
                        state_d = ST_LP_EXPECTED;
                        label_d = '0;
                    end
                end else if (instr_valid_i && en_i && dec_arm) begin
                    state_d = ST_LP_EXPECTED;
                    label_d = label_i;
                end
            end
            ST_LP_EXPECTED: begin
                if (elp_load_i) begin
                    if (elp_val_i) begin
                        label_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (instr_valid_i) begin
                    if (dec_lpad && label_ok) begin
                        state_d = ST_IDLE;
                    end else if (dec_lpad) begin
                        state_d = ST_FAULT;
                        cause_d = CAUSE_LABEL_MISMATCH;
                    end else begin
                        state_d = ST_FAULT;
                        cause_d = CAUSE_MISSING_LPAD;
                    end
                end
            end
            ST_FAULT: begin
                if (trap_ack_i) begin
                    state_d = ST_IDLE;
                    cause_d = CAUSE_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    assign elp_o      = (state_q != ST_IDLE);
    assign ex_o       = (state_q == ST_FAULT);
    assign ex_cause_o = cause_q;

`ifdef CFI_LP_FAULT_CNT_EN
    logic        fault_enter;
    logic [15:0] cnt_q;

    assign fault_enter = (state_q != ST_FAULT) && (state_d == ST_FAULT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 16'd0;
        end else if (fault_enter && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign fault_cnt_o = cnt_q;
`else
    assign fault_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_cfi_lp_checker.sv
// Scoreboard bench for cfi_lp_checker: a default instance plus a
// LABEL_W=8 / CALLS_ONLY=1 instance driven from the same stimulus.
module tb_cfi_lp_checker;

    localparam logic [31:0] J_X1_X6 = 32'h000300E7;
    localparam logic [31:0] J_X0_X5 = 32'h00028067;
    localparam logic [31:0] J_X0_X6 = 32'h00030067;
    localparam logic [31:0] J_X0_X7 = 32'h00038067;
    localparam logic [31:0] J_RET   = 32'h00008067;
    localparam logic [31:0] J_F3    = 32'h00031067;
    localparam logic [31:0] J_X1_X5 = 32'h000280E7;
    localparam logic [31:0] J_X5_X6 = 32'h000302E7;
    localparam logic [31:0] ADDI0   = 32'h00000013;

`ifdef CFI_LP_FAULT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i, instr_valid_i, elp_load_i, elp_val_i, trap_ack_i;
    logic [31:0] instr_i;
    logic [19:0] label_i;
    logic        elp_o, ex_o, elp2, ex2;
    logic [1:0]  ex_cause_o, cause2;
    logic [15:0] fault_cnt_o, cnt2;

    typedef struct {
        string       name;
        logic        elp;
        logic        ex;
        logic [1:0]  cause;
        logic [15:0] cnt;
        logic        elp2;
        logic        ex2;
        logic [1:0]  cause2;
    } rec_t;

    rec_t sb[$];
    rec_t obs[$];
    int   checks = 0;
    int   errors = 0;
    int   flt_n  = 0;

    always #5 clk_i = ~clk_i;

    cfi_lp_checker dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .instr_valid_i(instr_valid_i),
        .instr_i(instr_i), .label_i(label_i), .elp_load_i(elp_load_i),
        .elp_val_i(elp_val_i), .trap_ack_i(trap_ack_i), .elp_o(elp_o), .ex_o(ex_o),
        .ex_cause_o(ex_cause_o), .fault_cnt_o(fault_cnt_o)
    );

    cfi_lp_checker #(.LABEL_W(8), .CALLS_ONLY(1)) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .instr_valid_i(instr_valid_i),
        .instr_i(instr_i), .label_i(label_i[19:12]), .elp_load_i(elp_load_i),
        .elp_val_i(elp_val_i), .trap_ack_i(trap_ack_i), .elp_o(elp2), .ex_o(ex2),
        .ex_cause_o(cause2), .fault_cnt_o(cnt2)
    );

    function automatic logic [31:0] lpad(input logic [19:0] l);
        return {l, 12'h017};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [19:0] lbl,
                         input logic en, input logic ld, input logic vl, input logic ack);
        rec_t o;
        instr_valid_i = v;  instr_i = ins;  label_i = lbl;  en_i = en;
        elp_load_i = ld;    elp_val_i = vl; trap_ack_i = ack;
        @(posedge clk_i);
        #1;
        o.name = "obs"; o.elp = elp_o; o.ex = ex_o; o.cause = ex_cause_o; o.cnt = fault_cnt_o;
        o.elp2 = elp2; o.ex2 = ex2; o.cause2 = cause2;
        obs.push_back(o);
    endtask

    task automatic push1(input string nm, input logic elp, input logic ex, input logic [1:0] c);
        rec_t e;
        e.name = nm; e.elp = elp; e.ex = ex; e.cause = c;
        e.cnt = CNT_ON ? 16'(flt_n) : 16'd0;
        e.elp2 = 1'b0; e.ex2 = 1'b0; e.cause2 = 2'b00;
        sb.push_back(e);
    endtask

    task automatic push2(input string nm, input logic elp, input logic ex, input logic [1:0] c);
        rec_t e;
        e.name = nm; e.elp = 1'b0; e.ex = 1'b0; e.cause = 2'b00; e.cnt = 16'd0;
        e.elp2 = elp; e.ex2 = ex; e.cause2 = c;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; en_i = 1'b0; instr_valid_i = 1'b0; instr_i = '0; label_i = '0;
        elp_load_i = 1'b0; elp_val_i = 1'b0; trap_ack_i = 1'b0;
        #13;
        checks++;
        if ({elp_o, ex_o, ex_cause_o, fault_cnt_o} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs: got elp=%0b ex=%0b cause=%0b cnt=%0d, expected all zero",
                     elp_o, ex_o, ex_cause_o, fault_cnt_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_match();
        drive(1, J_X1_X6, 20'h12345, 1, 0, 0, 0);        push1("arm_jalr_x1_x6", 1, 0, 2'b00);
        drive(0, ADDI0, 20'h0, 1, 0, 0, 0);              push1("hold_no_valid", 1, 0, 2'b00);
        drive(1, lpad(20'h12345), 20'h0, 1, 0, 0, 0);    push1("lpad_match", 0, 0, 2'b00);
        drive(1, lpad(20'h00042), 20'h0, 1, 0, 0, 0);    push1("lpad_in_idle_noop", 0, 0, 2'b00);
        drive(1, J_X0_X6, 20'h54321, 1, 0, 0, 0);        push1("arm_again", 1, 0, 2'b00);
        drive(1, lpad(20'h00000), 20'h0, 1, 0, 0, 0);    push1("lpad_zero_label", 0, 0, 2'b00);
        drive(1, J_RET, 20'h11111, 1, 0, 0, 0);          push1("ret_no_arm", 0, 0, 2'b00);
        drive(1, J_F3, 20'h11111, 1, 0, 0, 0);           push1("funct3_no_arm", 0, 0, 2'b00);
        while (sb.size() != 0) begin
            rec_t e, o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if ({o.elp, o.ex, o.cause, o.cnt} !== {e.elp, e.ex, e.cause, e.cnt}) begin
                errors++;
                $display("FAIL %s: got elp=%0b ex=%0b cause=%0b cnt=%0d, expected elp=%0b ex=%0b cause=%0b cnt=%0d",
                         e.name, o.elp, o.ex, o.cause, o.cnt, e.elp, e.ex, e.cause, e.cnt);
            end
        end
    endtask

    task automatic test_mismatch();
        drive(1, J_X1_X6, 20'h12345, 1, 0, 0, 0);        push1("mm_arm", 1, 0, 2'b00);
        drive(1, lpad(20'h00042), 20'h0, 1, 0, 0, 0);    flt_n++; push1("mm_fault", 1, 1, 2'b10);
        drive(1, lpad(20'h12345), 20'h0, 1, 0, 0, 0);    push1("mm_ignore_instr", 1, 1, 2'b10);
        drive(0, ADDI0, 20'h0, 1, 0, 0, 0);              push1("mm_hold", 1, 1, 2'b10);
        drive(0, ADDI0, 20'h0, 1, 0, 0, 1);              push1("mm_trap_ack", 0, 0, 2'b00);
        drive(0, ADDI0, 20'h0, 1, 0, 0, 0);              push1("mm_idle_after", 0, 0, 2'b00);
        while (sb.size() != 0) begin
            rec_t e, o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if ({o.elp, o.ex, o.cause, o.cnt} !== {e.elp, e.ex, e.cause, e.cnt}) begin
                errors++;
                $display("FAIL %s: got elp=%0b ex=%0b cause=%0b cnt=%0d, expected elp=%0b ex=%0b cause=%0b cnt=%0d",
                         e.name, o.elp, o.ex, o.cause, o.cnt, e.elp, e.ex, e.cause, e.cnt);
            end
        end
    endtask

    task automatic test_missing();
        drive(1, J_X0_X6, 20'h55555, 1, 0, 0, 0);        push1("ms_arm", 1, 0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            drive(0, ADDI0, 20'h0, 1, 0, 0, 0);          push1("ms_wait", 1, 0, 2'b00);
        end
        drive(1, ADDI0, 20'h0, 1, 0, 0, 0);              flt_n++; push1("ms_addi_fault", 1, 1, 2'b01);
        drive(0, ADDI0, 20'h0, 1, 0, 0, 1);              push1("ms_ack", 0, 0, 2'b00);
        drive(1, J_X1_X6, 20'h00001, 1, 0, 0, 0);        push1("ms_arm2", 1, 0, 2'b00);
        drive(1, J_X1_X6, 20'h00001, 1, 0, 0, 0);        flt_n++; push1("ms_jump_fault", 1, 1, 2'b01);
        drive(0, ADDI0, 20'h0, 1, 1, 0, 0);              push1("ms_load_ignored", 1, 1, 2'b01);
        drive(0, ADDI0, 20'h0, 1, 1, 1, 1);              push1("ms_ack_over_load", 0, 0, 2'b00);
        while (sb.size() != 0) begin
            rec_t e, o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if ({o.elp, o.ex, o.cause, o.cnt} !== {e.elp, e.ex, e.cause, e.cnt}) begin
                errors++;
                $display("FAIL %s: got elp=%0b ex=%0b cause=%0b cnt=%0d, expected elp=%0b ex=%0b cause=%0b cnt=%0d",
                         e.name, o.elp, o.ex, o.cause, o.cnt, e.elp, e.ex, e.cause, e.cnt);
            end
        end
    endtask

    task automatic test_arming_filter();
        drive(1, J_X0_X5, 20'h00123, 1, 0, 0, 0);        push1("flt_rs1_t0", 0, 0, 2'b00);
        drive(1, J_X0_X7, 20'h00123, 1, 0, 0, 0);        push1("flt_rs1_t2", 0, 0, 2'b00);
        drive(1, J_X1_X5, 20'h00123, 1, 0, 0, 0);        push1("flt_call_via_t0", 0, 0, 2'b00);
        drive(1, J_X0_X6, 20'h00123, 0, 0, 0, 0);        push1("flt_en_low", 0, 0, 2'b00);
        drive(0, J_X0_X6, 20'h00123, 1, 0, 0, 0);        push1("flt_not_valid", 0, 0, 2'b00);
        drive(1, J_X0_X6, 20'h00123, 1, 0, 0, 0);        push1("flt_rs1_x6_arms", 1, 0, 2'b00);
        drive(1, lpad(20'h00123), 20'h0, 1, 0, 0, 0);    push1("flt_lpad_ok", 0, 0, 2'b00);
        while (sb.size() != 0) begin
            rec_t e, o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if ({o.elp, o.ex, o.cause, o.cnt} !== {e.elp, e.ex, e.cause, e.cnt}) begin
                errors++;
                $display("FAIL %s: got elp=%0b ex=%0b cause=%0b cnt=%0d, expected elp=%0b ex=%0b cause=%0b cnt=%0d",
                         e.name, o.elp, o.ex, o.cause, o.cnt, e.elp, e.ex, e.cause, e.cnt);
            end
        end
    endtask

    task automatic test_elp_load();
        drive(0, ADDI0, 20'h0, 1, 1, 1, 0);              push1("ld_set", 1, 0, 2'b00);
        drive(1, lpad(20'h00777), 20'h0, 1, 0, 0, 0);    push1("ld_wildcard_lpad", 0, 0, 2'b00);
        drive(1, J_X0_X6, 20'h00999, 1, 1, 0, 0);        push1("ld_clear_over_arm", 0, 0, 2'b00);
        drive(0, ADDI0, 20'h0, 1, 1, 1, 0);              push1("ld_set2", 1, 0, 2'b00);
        drive(1, ADDI0, 20'h0, 1, 1, 1, 0);              push1("ld_over_instr", 1, 0, 2'b00);
        drive(0, ADDI0, 20'h0, 1, 1, 0, 0);              push1("ld_clear", 0, 0, 2'b00);
        while (sb.size() != 0) begin
            rec_t e, o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if ({o.elp, o.ex, o.cause, o.cnt} !== {e.elp, e.ex, e.cause, e.cnt}) begin
                errors++;
                $display("FAIL %s: got elp=%0b ex=%0b cause=%0b cnt=%0d, expected elp=%0b ex=%0b cause=%0b cnt=%0d",
                         e.name, o.elp, o.ex, o.cause, o.cnt, e.elp, e.ex, e.cause, e.cnt);
            end
        end
    endtask

    task automatic test_en_drop_and_reset();
        drive(1, J_X1_X6, 20'h0ABCD, 1, 0, 0, 0);        push1("en_arm", 1, 0, 2'b00);
        drive(1, ADDI0, 20'h0, 0, 0, 0, 0);              push1("en_drop_idle", 0, 0, 2'b00);
        drive(1, J_X1_X6, 20'h0ABCD, 1, 0, 0, 0);        push1("rst_arm", 1, 0, 2'b00);
        drive(1, lpad(20'h0ABCE), 20'h0, 1, 0, 0, 0);    flt_n++; push1("rst_fault", 1, 1, 2'b10);
        while (sb.size() != 0) begin
            rec_t e, o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if ({o.elp, o.ex, o.cause, o.cnt} !== {e.elp, e.ex, e.cause, e.cnt}) begin
                errors++;
                $display("FAIL %s: got elp=%0b ex=%0b cause=%0b cnt=%0d, expected elp=%0b ex=%0b cause=%0b cnt=%0d",
                         e.name, o.elp, o.ex, o.cause, o.cnt, e.elp, e.ex, e.cause, e.cnt);
            end
        end
        // asynchronous reset in the middle of FAULT
        #2;
        rst_ni = 1'b0;
        #1;
        flt_n = 0;
        checks++;
        if ({elp_o, ex_o, ex_cause_o, fault_cnt_o} !== 20'd0) begin
            errors++;
            $display("FAIL rst_in_fault: got elp=%0b ex=%0b cause=%0b cnt=%0d, expected all zero",
                     elp_o, ex_o, ex_cause_o, fault_cnt_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(1, J_X0_X6, 20'h00321, 1, 0, 0, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({elp_o, ex_o, ex_cause_o} !== 4'd0) begin
            errors++;
            $display("FAIL rst_in_lp: got elp=%0b ex=%0b cause=%0b, expected zero", elp_o, ex_o, ex_cause_o);
        end
        obs.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(1, ADDI0, 20'h0, 1, 0, 0, 0);              push1("rst_no_ex_pulse", 0, 0, 2'b00);
        while (sb.size() != 0) begin
            rec_t e, o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if ({o.elp, o.ex, o.cause, o.cnt} !== {e.elp, e.ex, e.cause, e.cnt}) begin
                errors++;
                $display("FAIL %s: got elp=%0b ex=%0b cause=%0b cnt=%0d, expected elp=%0b ex=%0b cause=%0b cnt=%0d",
                         e.name, o.elp, o.ex, o.cause, o.cnt, e.elp, e.ex, e.cause, e.cnt);
            end
        end
    endtask

    task automatic test_calls_only();
        drive(1, J_X0_X6, 20'h12345, 1, 0, 0, 0);        push2("co_no_link_no_arm", 0, 0, 2'b00);
        drive(1, lpad(20'h00000), 20'h0, 1, 0, 0, 0);    push2("co_lpad_idle", 0, 0, 2'b00);
        drive(1, J_X1_X5, 20'h12345, 1, 0, 0, 0);        push2("co_call_arms", 1, 0, 2'b00);
        drive(1, lpad(20'h12999), 20'h0, 1, 0, 0, 0);    push2("co_8bit_match", 0, 0, 2'b00);
        drive(1, J_X5_X6, 20'hAB000, 1, 0, 0, 0);        push2("co_t0_link_arms", 1, 0, 2'b00);
        drive(1, lpad(20'hAC000), 20'h0, 1, 0, 0, 0);    push2("co_8bit_mismatch", 1, 1, 2'b10);
        drive(0, ADDI0, 20'h0, 1, 0, 0, 1);              push2("co_ack", 0, 0, 2'b00);
        drive(1, J_X1_X6, 20'hCD000, 1, 0, 0, 0);        push2("co_arm3", 1, 0, 2'b00);
        drive(1, lpad(20'h00FFF), 20'h0, 1, 0, 0, 0);    push2("co_8bit_zero_field", 0, 0, 2'b00);
        while (sb.size() != 0) begin
            rec_t e, o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if ({o.elp2, o.ex2, o.cause2} !== {e.elp2, e.ex2, e.cause2}) begin
                errors++;
                $display("FAIL %s: got elp=%0b ex=%0b cause=%0b, expected elp=%0b ex=%0b cause=%0b",
                         e.name, o.elp2, o.ex2, o.cause2, e.elp2, e.ex2, e.cause2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_missing();
        test_arming_filter();
        test_elp_load();
        test_en_drop_and_reset();
        test_calls_only();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
